ov_frame_ctrl: RTL and testbench

- Capture sequencer for the OV7670 → AL422B FIFO write side, running in the 25 MHz camera clock domain.
- Arms on a capture request and synchronises to camera VSYNC.
- Resets the FIFO write pointer, enables writes for exactly one frame, then hands the frame to the FIFO reader through the new_frame/frame_read handshake.
- Blocks any new capture until the reader reports done.

---
 rtl/ov_frame_ctrl_pkg.sv | 26 ++
 rtl/ov_frame_ctrl_if.sv | 36 +++
 rtl/ov_frame_ctrl_vsync_sync.sv | 45 ++++
 rtl/ov_frame_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_ov_frame_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ov_frame_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ov_pkg
// Shared definitions for the OV7670 -> AL422B capture-side blocks.
//   ov_state_t   : capture sequencer state encoding
//   FRAME_BYTES  : bytes in one QVGA RGB565 frame
//   CLK_HZ       : camera-domain clock frequency
//   FRAME_CNT_W  : width of the captured-frame counter
//   WD_W         : watchdog counter width (holds 1 s at CLK_HZ)
// ---------------------------------------------------------------------------
package ov_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARM     = 3'd1,
      S_WRST    = 3'd2,
      S_WRITE   = 3'd3,
      S_HANDOFF = 3'd4,
      S_DRAIN   = 3'd5
   } ov_state_t;

   localparam int FRAME_BYTES = 320 * 240 * 2;
   localparam int CLK_HZ      = 25_000_000;
   localparam int FRAME_CNT_W = 8;
   localparam int WD_W        = 25;

endpackage

// File: rtl/ov_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// ov_frame_ctrl_if
// Control/status bundle between the capture sequencer and its surroundings
// (camera, config block, FIFO, FIFO reader).
//   master : the sequencer (drives FIFO controls and status)
//   slave  : the environment (drives camera/config/reader inputs)
// Signals:
//   initialized, vsync, capture_req, continuous, frame_read  (to sequencer)
//   wen, wrst, new_frame, busy, frame_cnt[7:0], timeout       (from sequencer)
// ---------------------------------------------------------------------------
interface ov_frame_ctrl_if;
   import ov_pkg::*;

   logic                   initialized;
   logic                   vsync;
   logic                   capture_req;
   logic                   continuous;
   logic                   frame_read;
   logic                   wen;
   logic                   wrst;
   logic                   new_frame;
   logic                   busy;
   logic [FRAME_CNT_W-1:0] frame_cnt;
   logic                   timeout;

   modport master (
      input  initialized, vsync, capture_req, continuous, frame_read,
      output wen, wrst, new_frame, busy, frame_cnt, timeout
   );

   modport slave (
      output initialized, vsync, capture_req, continuous, frame_read,
      input  wen, wrst, new_frame, busy, frame_cnt, timeout
   );

endinterface

// File: rtl/ov_frame_ctrl_vsync_sync.sv
// ---------------------------------------------------------------------------
// ov_vsync_sync
// Brings the asynchronous camera VSYNC into the camera clock domain and
// flags its active edge. Polarity is normalised before the first flop so
// the rise detector always sees an active-high pulse.
// Ports:
//   clk_25MHz  in   camera-domain clock
//   rst_n      in   asynchronous active-low reset
//   vsync      in   raw VSYNC pin
//   vs_rise    out  one-cycle pulse, high the cycle after s2 goes high
// Parameters:
//   VSYNC_POL  1 = active-high VSYNC, 0 = active-low
// ---------------------------------------------------------------------------
module ov_vsync_sync
   import ov_pkg::*;
#(
   parameter bit VSYNC_POL = 1'b1
) (
   input  logic clk_25MHz,
   input  logic rst_n,
   input  logic vsync,
   output logic vs_rise
);

   logic vs_in;
   logic s1, s2, s3;

   assign vs_in = VSYNC_POL ? vsync : ~vsync;

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= vs_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // s1 may be metastable; the edge is taken between the two settled flops.
   assign vs_rise = s2 & ~s3;

endmodule

// File: rtl/ov_frame_ctrl.sv
// ---------------------------------------------------------------------------
// ov_frame_ctrl
// Write-side capture sequencer for an OV7670 feeding an AL422B FIFO.
// Arms on a capture request (or continuously), waits for a VSYNC edge,
// pulses the FIFO write-pointer reset, enables writes for exactly one frame
// and then hands the frame to the reader via new_frame / frame_read.
// No new capture starts until the reader reports it is idle again.
//
// Ports:
//   clk_25MHz  in   camera-domain clock
//   rst_n      in   asynchronous active-low reset
//   bus        ov_frame_ctrl_if.master
//     initialized  in   SCCB config done; gates capture
//     vsync        in   raw camera VSYNC (asynchronous)
//     capture_req  in   single-cycle capture request
//     continuous   in   re-arm after every read-out
//     frame_read   in   reader status: 1 idle, 0 reading
//     wen          out  FIFO write enable (active high)
//     wrst         out  FIFO write-pointer reset (active low)
//     new_frame    out  complete frame waiting in FIFO
//     busy         out  high in every state except IDLE
//     frame_cnt    out  frames captured, wraps 255 -> 0
//     timeout      out  sticky watchdog flag
// Parameters:
//   WRST_CYCLES     clocks wrst is held low at frame start (>= 1)
//   VSYNC_POL       1 = active-high VSYNC, 0 = active-low
//   TIMEOUT_CYCLES  watchdog limit in clocks
// Build option:
//   OV_FRAME_CTRL_TIMEOUT_EN  enables the ARM/WRITE watchdog; when undefined
//                             there is no counter and timeout is tied low.
// ---------------------------------------------------------------------------
module ov_frame_ctrl
   import ov_pkg::*;
#(
   parameter int WRST_CYCLES    = 4,
   parameter bit VSYNC_POL      = 1'b1,
   parameter int TIMEOUT_CYCLES = CLK_HZ
) (
   input  logic            clk_25MHz,
   input  logic            rst_n,
   ov_frame_ctrl_if.master bus
);

   localparam int CNT_W = (WRST_CYCLES > 1) ? $clog2(WRST_CYCLES) : 1;
   localparam logic [CNT_W-1:0] WRST_LOAD = CNT_W'(WRST_CYCLES - 1);

   if (WRST_CYCLES < 1 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (2 ** WD_W)) begin : g_bad_param
      $error("ov_frame_ctrl: parameter out of range");
   end

   ov_state_t              state;
   logic                   pending;
   logic [CNT_W-1:0]       wrst_cnt;
   logic                   wen_q;
   logic                   wrst_q;
   logic                   new_frame_q;
   logic                   busy_q;
   logic [FRAME_CNT_W-1:0] frame_cnt_q;
   logic                   vs_rise;
   logic                   in_capture;
   logic                   abort;

   ov_vsync_sync #(
      .VSYNC_POL (VSYNC_POL)
   ) u_vsync_sync (
      .clk_25MHz (clk_25MHz),
      .rst_n     (rst_n),
      .vsync     (bus.vsync),
      .vs_rise   (vs_rise)
   );

   // Losing the camera config only matters while we own the FIFO write
   // side; once the frame is handed off the reader handshake must finish.
   assign in_capture = (state == S_ARM) || (state == S_WRST) || (state == S_WRITE);
   assign abort      = in_capture && !bus.initialized;

`ifdef OV_FRAME_CTRL_TIMEOUT_EN
   logic [WD_W-1:0] wd_cnt;
   logic            wd_hit;
   logic            timeout_q;

   // Counting only in ARM/WRITE and clearing everywhere else is equivalent
   // to clearing on every state change: ARM is only entered from IDLE or
   // DRAIN, WRITE only from WRST, and every exit lands in a clearing state.
   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt <= '0;
      end else if (state == S_ARM || state == S_WRITE) begin
         wd_cnt <= wd_cnt + 1'b1;
      end else begin
         wd_cnt <= '0;
      end
   end

   assign wd_hit = ((state == S_ARM) || (state == S_WRITE)) &&
                   (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`endif

   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         pending     <= 1'b0;
         wrst_cnt    <= '0;
         wen_q       <= 1'b0;
         wrst_q      <= 1'b1;
         new_frame_q <= 1'b0;
         busy_q      <= 1'b0;
         frame_cnt_q <= '0;
`ifdef OV_FRAME_CTRL_TIMEOUT_EN
         timeout_q   <= 1'b0;
`endif
      end else begin
         // One-deep request latch; the ARM-entry clear below takes priority.
         if (bus.capture_req) pending <= 1'b1;

         if (abort) begin
            wen_q  <= 1'b0;
            wrst_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= S_IDLE;
         end
`ifdef OV_FRAME_CTRL_TIMEOUT_EN
         else if (wd_hit) begin
            timeout_q <= 1'b1;
            wen_q     <= 1'b0;
            wrst_q    <= 1'b1;
            busy_q    <= 1'b0;
            pending   <= 1'b0;
            state     <= S_IDLE;
         end
`endif
         else begin
            case (state)
               S_IDLE: begin
                  if (bus.initialized && bus.frame_read &&
                      (pending || bus.capture_req || bus.continuous)) begin
                     pending <= 1'b0;
                     busy_q  <= 1'b1;
                     state   <= S_ARM;
                  end
               end

               S_ARM: begin
                  if (vs_rise) begin
                     wrst_q   <= 1'b0;
                     wrst_cnt <= WRST_LOAD;
                     state    <= S_WRST;
                  end
               end

               // vs_rise is deliberately ignored here: a boundary landing
               // inside the reset pulse just defers end-of-frame to the next.
               S_WRST: begin
                  if (wrst_cnt == '0) begin
                     wrst_q <= 1'b1;
                     wen_q  <= 1'b1;
                     state  <= S_WRITE;
                  end else begin
                     wrst_cnt <= wrst_cnt - 1'b1;
                  end
               end

               S_WRITE: begin
                  if (vs_rise) begin
                     wen_q       <= 1'b0;
                     frame_cnt_q <= frame_cnt_q + 1'b1;
                     new_frame_q <= 1'b1;
                     state       <= S_HANDOFF;
                  end
               end

               S_HANDOFF: begin
                  if (!bus.frame_read) begin
                     new_frame_q <= 1'b0;
                     state       <= S_DRAIN;
                  end
               end

               S_DRAIN: begin
                  if (bus.frame_read) begin
                     if (bus.continuous || pending) begin
                        pending <= 1'b0;
                        state   <= S_ARM;
                     end else begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                     end
                  end
               end

               default: begin
                  wen_q       <= 1'b0;
                  wrst_q      <= 1'b1;
                  new_frame_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state       <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.wen       = wen_q;
   assign bus.wrst      = wrst_q;
   assign bus.new_frame = new_frame_q;
   assign bus.busy      = busy_q;
   assign bus.frame_cnt = frame_cnt_q;
`ifdef OV_FRAME_CTRL_TIMEOUT_EN
   assign bus.timeout   = timeout_q;
`else
   assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_ov_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ov_frame_ctrl
// Directed bench for ov_frame_ctrl: single shot, reader handshake, request
// while busy, abort, asynchronous reset, continuous mode with counter wrap,
// and (when OV_FRAME_CTRL_TIMEOUT_EN is defined) the watchdog.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ov_frame_ctrl;
   import ov_pkg::*;

   logic clk_25MHz = 1'b0;
   logic rst_n     = 1'b0;
   int   n_chk     = 0;
   int   n_err     = 0;
   int   excl_viol = 0;
   int   rd_viol   = 0;

   ov_frame_ctrl_if bus ();

   ov_frame_ctrl #(
      .WRST_CYCLES    (4),
      .VSYNC_POL      (1'b1),
      .TIMEOUT_CYCLES (1000)
   ) dut (
      .clk_25MHz (clk_25MHz),
      .rst_n     (rst_n),
      .bus       (bus)
   );

   always #20 clk_25MHz = ~clk_25MHz;

   // Invariants watched every cycle, reported once at the end.
   always @(negedge clk_25MHz) begin
      if (rst_n) begin
         if (bus.wen && !bus.wrst)      excl_viol++;
         if (bus.wen && !bus.frame_read) rd_viol++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_25MHz);
   endtask

   // Returns just after the 3rd rising edge, where the FSM has acted.
   task automatic vs_pulse();
      bus.vsync = 1'b1;
      tick(3);
      bus.vsync = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic req_pulse();
      bus.capture_req = 1'b1;
      tick(1);
      bus.capture_req = 1'b0;
   endtask

   // One full frame starting in ARM; optionally probes the DRAIN window.
   task automatic one_frame(input bit drain_chk);
      vs_pulse();
      tick(6);
      vs_pulse();
      tick(2);
      bus.frame_read = 1'b0;
      tick(3);
      if (drain_chk) begin
         vs_pulse();
         chk("drain_wrst", bus.wrst, 1);
         chk("drain_busy", bus.busy, 1);
         tick(3);
      end
      bus.frame_read = 1'b1;
      tick(1);
      if (drain_chk) begin
         chk("rearm_busy", bus.busy, 1);
         chk("rearm_wrst", bus.wrst, 1);
      end
   endtask

   initial begin
      bus.initialized = 1'b1;
      bus.vsync       = 1'b0;
      bus.capture_req = 1'b0;
      bus.continuous  = 1'b0;
      bus.frame_read  = 1'b1;
      tick(2);

      // Reset state
      chk("rst_wen",       bus.wen, 0);
      chk("rst_wrst",      bus.wrst, 1);
      chk("rst_new_frame", bus.new_frame, 0);
      chk("rst_busy",      bus.busy, 0);
      chk("rst_frame_cnt", bus.frame_cnt, 0);
      chk("rst_timeout",   bus.timeout, 0);
      rst_n = 1'b1;
      tick(2);
      chk("idle_busy", bus.busy, 0);

      // Single shot
      req_pulse();
      chk("arm_busy", bus.busy, 1);
      tick(5);
      bus.vsync = 1'b1;
      tick(2);
      chk("wrst_pre", bus.wrst, 1);
      tick(1);
      bus.vsync = 1'b0;
      chk("wrst_lo",    bus.wrst, 0);
      chk("wrst_lo_wen", bus.wen, 0);
      tick(3);
      chk("wrst_lo_4th", bus.wrst, 0);
      tick(1);
      chk("wrst_rel", bus.wrst, 1);
      chk("wen_on",   bus.wen, 1);
      tick(50);
      chk("wen_hold", bus.wen, 1);
      bus.vsync = 1'b1;
      tick(2);
      chk("wen_pre_eof", bus.wen, 1);
      tick(1);
      bus.vsync = 1'b0;
      chk("eof_wen",       bus.wen, 0);
      chk("eof_new_frame", bus.new_frame, 1);
      chk("eof_frame_cnt", bus.frame_cnt, 1);

      // Reader handshake
      tick(5);
      chk("nf_hold", bus.new_frame, 1);
      bus.frame_read = 1'b0;
      tick(1);
      chk("nf_drop",   bus.new_frame, 0);
      chk("read_busy", bus.busy, 1);
      tick(100);
      vs_pulse();
      tick(1900);
      chk("read_wen",  bus.wen, 0);
      chk("read_wrst", bus.wrst, 1);
      bus.frame_read = 1'b1;
      tick(1);
      chk("done_busy", bus.busy, 0);

      // Request while busy: two requests in one frame give one extra frame
      do_reset();
      req_pulse();
      vs_pulse();
      tick(6);
      chk("rq_wen", bus.wen, 1);
      req_pulse();
      tick(3);
      req_pulse();
      tick(2);
      vs_pulse();
      chk("rq_nf", bus.new_frame, 1);
      tick(2);
      bus.frame_read = 1'b0;
      tick(3);
      bus.frame_read = 1'b1;
      tick(1);
      chk("rq_rearm", bus.busy, 1);
      vs_pulse();
      tick(6);
      chk("rq2_wen", bus.wen, 1);
      vs_pulse();
      chk("rq2_cnt", bus.frame_cnt, 2);
      tick(2);
      bus.frame_read = 1'b0;
      tick(3);
      bus.frame_read = 1'b1;
      tick(1);
      chk("rq_idle", bus.busy, 0);
      tick(10);
      vs_pulse();
      chk("rq_no_third", bus.wrst, 1);
      chk("rq_no_third_busy", bus.busy, 0);

      // Abort mid-WRITE
      req_pulse();
      vs_pulse();
      tick(6);
      chk("ab_wen_pre", bus.wen, 1);
      bus.initialized = 1'b0;
      tick(1);
      chk("ab_wen",  bus.wen, 0);
      chk("ab_busy", bus.busy, 0);
      chk("ab_cnt",  bus.frame_cnt, 2);
      chk("ab_wrst", bus.wrst, 1);
      bus.initialized = 1'b1;
      tick(3);
      chk("ab_stay_idle", bus.busy, 0);

      // Asynchronous reset mid-WRST
      req_pulse();
      vs_pulse();
      tick(1);
      chk("ar_wrst_pre", bus.wrst, 0);
      #5;
      rst_n = 1'b0;
      #1;
      chk("ar_wrst", bus.wrst, 1);
      chk("ar_wen",  bus.wen, 0);
      chk("ar_busy", bus.busy, 0);
      chk("ar_cnt",  bus.frame_cnt, 0);
      tick(2);
      rst_n = 1'b1;
      tick(2);

      // Continuous mode, then run the counter through its wrap
      bus.continuous = 1'b1;
      tick(1);
      chk("ct_arm", bus.busy, 1);
      for (int i = 0; i < 3; i++) one_frame(1'b1);
      chk("ct_cnt3", bus.frame_cnt, 3);
      for (int i = 0; i < 251; i++) one_frame(1'b0);
      chk("ct_cnt254", bus.frame_cnt, 254);
      for (int i = 0; i < 3; i++) one_frame(1'b0);
      chk("ct_wrap", bus.frame_cnt, 1);
      bus.continuous  = 1'b0;
      bus.initialized = 1'b0;
      tick(1);
      chk("ct_stop", bus.busy, 0);
      bus.initialized = 1'b1;

`ifdef OV_FRAME_CTRL_TIMEOUT_EN
      // Watchdog: armed with no VSYNC
      do_reset();
      req_pulse();
      tick(999);
      chk("wd_pre",      bus.timeout, 0);
      chk("wd_pre_busy", bus.busy, 1);
      tick(1);
      chk("wd_flag", bus.timeout, 1);
      chk("wd_idle", bus.busy, 0);
      chk("wd_wrst", bus.wrst, 1);
      tick(5);
      chk("wd_sticky", bus.timeout, 1);
`endif

      chk("wen_wrst_excl",   excl_viol, 0);
      chk("wen_during_read", rd_viol, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
